// File: rtl/taxi_eth_stat_accum_if.sv
// Minimal AXI-Stream interface carrying the MAC statistics beats (data, id, user).
interface taxi_axis_if #(
   parameter int DATA_W = 16,
   parameter int ID_W   = 8,
   parameter int USER_W = 1
);
   logic [DATA_W-1:0] tdata;
   logic [ID_W-1:0]   tid;
   logic [USER_W-1:0] tuser;
   logic              tvalid;
   logic              tready;

   modport src  (output tdata, tid, tuser, tvalid, input  tready);
   modport sink (input  tdata, tid, tuser, tvalid, output tready);
endinterface

// File: rtl/taxi_eth_stat_accum.sv
// Accumulates (index, increment) stat beats into a RAM counter bank with a
// 2-stage read/modify/write pipeline and a host read port with clear-on-read.
module taxi_eth_stat_accum #(
   parameter int STAT_INC_W = 16,
   parameter int STAT_ID_W  = 8,
   parameter int CNT_W      = 64,
   parameter int N_CNT      = 2**STAT_ID_W
) (
   input  logic                 clk,
   input  logic                 rst,
   taxi_axis_if.sink            s_axis_stat,
   input  logic [STAT_ID_W-1:0] rd_req_addr,
   input  logic                 rd_req_clear,
   input  logic                 rd_req_valid,
   output logic                 rd_req_ready,
   output logic [CNT_W-1:0]     rd_rsp_data,
   output logic                 rd_rsp_valid,
   output logic                 busy
);
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t               r_state, w_next_state;
   logic [STAT_ID_W-1:0] r_ptr;
   logic [CNT_W-1:0]     r_mem [N_CNT];

   logic                 w_rd_acc, w_st_acc;
   logic [STAT_ID_W-1:0] w_s1_addr;

   logic                  r_s2_valid, r_s2_is_rd, r_s2_clear, r_s2_fwd;
   logic [STAT_ID_W-1:0]  r_s2_addr;
   logic [STAT_INC_W-1:0] r_s2_inc;
   logic [CNT_W-1:0]      r_ram_q, r_fwd_data, w_s2_old, w_s2_result;

   logic                 w_we;
   logic [STAT_ID_W-1:0] w_waddr;
   logic [CNT_W-1:0]     w_wdata;
   logic                 w_unused_tuser;

   assign w_unused_tuser = s_axis_stat.tuser;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (r_state == ST_INIT && r_ptr == STAT_ID_W'(N_CNT-1))
         w_next_state = ST_RUN;
   end

   // Reads always win arbitration, so a pending read holds off the stat stream.
   always_comb begin
      busy               = (r_state == ST_INIT);
      rd_req_ready       = (r_state == ST_RUN);
      s_axis_stat.tready = (r_state == ST_RUN) && !rd_req_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_ptr <= '0;
      else if (r_state == ST_INIT) r_ptr <= r_ptr + 1'b1;
   end

   assign w_rd_acc  = rd_req_valid && rd_req_ready;
   assign w_st_acc  = s_axis_stat.tvalid && s_axis_stat.tready;
   assign w_s1_addr = w_rd_acc ? rd_req_addr : s_axis_stat.tid;

   // The S2 write lands on the same edge as the S1 RAM read, so same-address
   // back-to-back ops take the S2 result captured alongside the RAM data.
   assign w_s2_old = r_s2_fwd ? r_fwd_data : r_ram_q;

   always_comb begin
      w_s2_result = w_s2_old + CNT_W'(r_s2_inc);
      if (r_s2_is_rd) w_s2_result = r_s2_clear ? '0 : w_s2_old;
   end

   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_s2_addr;
      w_wdata = w_s2_result;
      if (r_state == ST_INIT) begin
         w_we    = 1'b1;
         w_waddr = r_ptr;
         w_wdata = '0;
      end else if (r_s2_valid && (!r_s2_is_rd || r_s2_clear)) begin
         w_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
      r_ram_q <= r_mem[w_s1_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid   <= 1'b0;
         r_s2_is_rd   <= 1'b0;
         r_s2_clear   <= 1'b0;
         r_s2_fwd     <= 1'b0;
         r_s2_addr    <= '0;
         r_s2_inc     <= '0;
         r_fwd_data   <= '0;
         rd_rsp_valid <= 1'b0;
         rd_rsp_data  <= '0;
      end else begin
         r_s2_valid   <= w_rd_acc || w_st_acc;
         r_s2_is_rd   <= w_rd_acc;
         r_s2_clear   <= rd_req_clear;
         r_s2_fwd     <= r_s2_valid && (r_s2_addr == w_s1_addr);
         r_s2_addr    <= w_s1_addr;
         r_s2_inc     <= s_axis_stat.tdata;
         r_fwd_data   <= w_s2_result;
         rd_rsp_valid <= r_s2_valid && r_s2_is_rd;
         if (r_s2_valid && r_s2_is_rd) rd_rsp_data <= w_s2_old;
      end
   end
endmodule

// File: doc/taxi_eth_stat_accum.md
Name: taxi_eth_stat_accum

Overview:
- Sink-side accumulator for the MAC statistics stream.
- Each stream beat is a (counter index, increment) pair, as emitted by the MAC stat output. The block adds the increment into a RAM-resident counter bank.
- Exposes a host read port with optional clear-on-read.
- Sits in the logic/stat clock domain between the MAC stat output and the register/CSR layer.

Parameters:
- STAT_INC_W, 16, width of the increment field (s_axis_stat.tdata).
- STAT_ID_W, 8, width of the counter index (s_axis_stat.tid).
- CNT_W, 64, width of each accumulated counter.
- N_CNT, 2**STAT_ID_W, number of counters.

Ports:
- clk  in  1  block clock.
- rst  in  1  reset; asynchronous, active-high.
- s_axis_stat  taxi_axis_if sink  tdata STAT_INC_W / tid STAT_ID_W / tuser 1  stat beats (KEEP_EN=0, LAST_EN=0; tuser ignored).
- rd_req_addr  in  STAT_ID_W  counter index to read.
- rd_req_clear  in  1  zero the counter as part of this read.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted when valid&&ready.
- rd_rsp_data  out  CNT_W  counter value before any clear.
- rd_rsp_valid  out  1  single-cycle pulse; no backpressure.
- busy  out  1  high while zero-initialising.

Behaviour:
- Reset values: s_axis_stat.tready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, busy=1; pipeline valid bits=0; FSM=INIT, init pointer=0.
- FSM INIT: write 0 to RAM[ptr] each cycle and increment ptr. After writing N_CNT-1, go to RUN next cycle; busy=0 in RUN. INIT takes exactly N_CNT cycles. All handshakes are deasserted in INIT.
- FSM RUN: arbiter selects one operation per cycle.
  - A valid read request wins.
  - Otherwise a valid stat beat is taken.
  - rd_req_ready = (state==RUN).
  - s_axis_stat.tready = (state==RUN) && !rd_req_valid.
- Pipeline:
  - S1 (accept cycle): RAM read at the address.
  - S2 (next cycle): compute the result and write back.
  - Stat op: RAM <= old + zero-extended increment, modulo 2^CNT_W (wrap, no saturation).
  - Read op: rd_rsp_data <= old and rd_rsp_valid=1 on the cycle after S2, i.e. response latency is 2 cycles from acceptance. If clear is set, RAM <= 0 in S2; otherwise no write.
- Hazard forwarding: if the S1 address equals the S2 address with S2 valid, S1 uses the S2 result instead of the RAM output. Back-to-back ops to the same counter therefore never lose updates; throughput is one op per cycle.
- Read-after-stat: a read accepted the cycle after a stat beat to the same index returns the updated value.
- Increment of 0 is a legal beat and leaves the counter unchanged.
- Simultaneous read request and stat beat: the read is accepted and the stat beat stalls (tready=0) for that cycle.
- rst assertion mid-operation: the pipeline is flushed, with no pending rd_rsp_valid emitted. RAM contents are undefined, and the block re-enters INIT and re-zeros all counters.

Test Plan:
- Reset release: busy=1 for exactly N_CNT=256 cycles; tready and rd_req_ready stay 0 until busy falls. Subsequent read of index 0x37 returns 0.
- Back-to-back beats: 4 consecutive beats to id 5 with increments 1, 2, 3, 0xFFFF, then a read of id 5 -> rd_rsp_data = 0x10005, arriving exactly 2 cycles after read acceptance.
- Wrap: preload id 9 to 2^64-1 via beats, then beat +2 -> read returns 1.
- Clear-on-read: id 3 holds 100; read with clear -> returns 100. Immediate second read (next cycle) -> returns 0. Beat +7, then read -> 7.
- Contention: rd_req_valid and a stat beat asserted on the same cycle for id 12 -> read accepted first and returns the pre-beat value. Beat accepted next cycle; a later read returns the pre-beat value plus the increment.
- Reset mid-stream: assert rst while a read is in S2 -> no rd_rsp_valid. After INIT, every index reads 0.
